// File: rtl/enc_link_rx_if.sv
// rtl/enc_link_rx_if.sv - put/get handshake bundle between encoder stage, receive FIFO and consumer
//
// Signals:
//   put_code   [2:0]  encoded code {a2,a1,a0} from the encoder stage
//   EN_put            put strobe
//   RDY_put           receiver can take a code
//   EN_get            get strobe
//   get_onehot [7:0]  decoded head entry
//   RDY_get           a decoded word is available
// Modports: master = producer/consumer side, slave = enc_link_rx.
interface enc_link_rx_if;
    logic [2:0] put_code;
    logic       EN_put;
    logic       RDY_put;
    logic       EN_get;
    logic [7:0] get_onehot;
    logic       RDY_get;

    modport master (
        output put_code,
        output EN_put,
        output EN_get,
        input  RDY_put,
        input  get_onehot,
        input  RDY_get
    );

    modport slave (
        input  put_code,
        input  EN_put,
        input  EN_get,
        output RDY_put,
        output get_onehot,
        output RDY_get
    );
endinterface

// File: rtl/enc_link_rx.sv
// rtl/enc_link_rx.sv - receive FIFO for 3-bit link codes with one-hot decode and drop counter
//
// Ports:
//   CLK        single clock, rising edge
//   RST_N      asynchronous active-low reset
//   lnk        enc_link_rx_if.slave: put_code/EN_put/RDY_put, EN_get/get_onehot/RDY_get
//   clr_drops  synchronous clear of drop_cnt (wins over a same-cycle drop)
//   occupancy  number of valid entries, 0..DEPTH
//   drop_cnt   saturating count of puts refused while full
module enc_link_rx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    enc_link_rx_if.slave             lnk,
    input  logic                     clr_drops,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] DROP_MAX = '1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW:0]     r_occ;
    logic [AW:0]     w_occ_nxt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [2:0]      r_mem [DEPTH];
    logic [CNT_W-1:0] r_drop;

    logic w_put_fire;
    logic w_get_fire;
    logic w_drop;

    // Ready flags decode only the registered state, so EN_* never reaches RDY_*.
    assign lnk.RDY_put = (r_state != S_FULL);
    assign lnk.RDY_get = (r_state != S_EMPTY);

    assign w_put_fire = lnk.EN_put & lnk.RDY_put;
    assign w_get_fire = lnk.EN_get & lnk.RDY_get;
    // A put while full is refused even if a get frees a slot this same cycle.
    assign w_drop     = lnk.EN_put & ~lnk.RDY_put;

    assign lnk.get_onehot = (r_state != S_EMPTY) ? (8'd1 << r_mem[r_rd_ptr]) : 8'h00;
    assign occupancy      = r_occ;
    assign drop_cnt       = r_drop;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_EMPTY;
            r_occ   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_occ   <= w_occ_nxt;
        end
    end

    // State tracks the next occupancy value so it always agrees with r_occ.
    always_comb begin
        w_occ_nxt   = r_occ;
        w_state_nxt = S_PARTIAL;
        case ({w_put_fire, w_get_fire})
            2'b10:   w_occ_nxt = r_occ + (AW+1)'(1);
            2'b01:   w_occ_nxt = r_occ - (AW+1)'(1);
            default: w_occ_nxt = r_occ;
        endcase
        if (w_occ_nxt == '0) begin
            w_state_nxt = S_EMPTY;
        end else if (w_occ_nxt == OCC_FULL) begin
            w_state_nxt = S_FULL;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_put_fire) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_get_fire) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read when occupancy says they are valid.
    always_ff @(posedge CLK) begin
        if (w_put_fire) begin
            r_mem[r_wr_ptr] <= lnk.put_code;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_drop <= '0;
        end else if (clr_drops) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != DROP_MAX)) begin
            r_drop <= r_drop + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_enc_link_rx.sv
// tb/tb_enc_link_rx.sv - self-checking bench for enc_link_rx
module tb_enc_link_rx;

    logic       CLK;
    logic       RST_N;
    logic       clr_drops;
    logic [2:0] occupancy;
    logic [7:0] drop_cnt;

    enc_link_rx_if lnk ();

    enc_link_rx #(.DEPTH(4), .CNT_W(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .lnk       (lnk.slave),
        .clr_drops (clr_drops),
        .occupancy (occupancy),
        .drop_cnt  (drop_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks;
    int n_errors;

    // Reference model
    logic [7:0] sb[$];
    int         m_occ;
    int         m_drop;

    typedef struct {
        logic       pe;
        logic [2:0] code;
        logic       ge;
        logic [7:0] exp_onehot;
        logic       exp_rdy_get;
        logic       exp_rdy_put;
        int         exp_occ;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: checks outputs against the model, clocks one edge, updates the model.
    task automatic cycle(input logic pe, input logic [2:0] code, input logic ge, input logic clr);
        logic put_f;
        logic get_f;
        logic drop_f;
        logic [7:0] exp_head;
        lnk.EN_put   = pe;
        lnk.put_code = code;
        lnk.EN_get   = ge;
        clr_drops    = clr;
        exp_head = (m_occ > 0) ? sb[0] : 8'h00;
        chk("rdy_put",   32'(lnk.RDY_put),    32'(m_occ < 4));
        chk("rdy_get",   32'(lnk.RDY_get),    32'(m_occ > 0));
        chk("occupancy", 32'(occupancy),      32'(m_occ));
        chk("onehot",    32'(lnk.get_onehot), 32'(exp_head));
        chk("drop_cnt",  32'(drop_cnt),       32'(m_drop));
        put_f  = pe && (m_occ < 4);
        get_f  = ge && (m_occ > 0);
        drop_f = pe && (m_occ == 4);
        @(posedge CLK);
        #1;
        if (get_f) void'(sb.pop_front());
        if (put_f) sb.push_back(8'd1 << code);
        if (put_f && !get_f) m_occ++;
        if (get_f && !put_f) m_occ--;
        if (clr) m_drop = 0;
        else if (drop_f && m_drop < 255) m_drop++;
        lnk.EN_put = 1'b0;
        lnk.EN_get = 1'b0;
        clr_drops  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_occ    = 0;
        m_drop   = 0;
        RST_N        = 1'b0;
        lnk.EN_put   = 1'b0;
        lnk.EN_get   = 1'b0;
        lnk.put_code = 3'd0;
        clr_drops    = 1'b0;

        //               pe  code  ge  onehot  rget rput occ
        vecs[0]  = '{1'b1, 3'd5, 1'b0, 8'h20, 1'b1, 1'b1, 1};
        vecs[1]  = '{1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 0};
        vecs[2]  = '{1'b1, 3'd7, 1'b0, 8'h80, 1'b1, 1'b1, 1};
        vecs[3]  = '{1'b1, 3'd0, 1'b0, 8'h80, 1'b1, 1'b1, 2};
        vecs[4]  = '{1'b1, 3'd3, 1'b0, 8'h80, 1'b1, 1'b1, 3};
        vecs[5]  = '{1'b1, 3'd6, 1'b0, 8'h80, 1'b1, 1'b0, 4};
        vecs[6]  = '{1'b0, 3'd0, 1'b1, 8'h01, 1'b1, 1'b1, 3};
        vecs[7]  = '{1'b0, 3'd0, 1'b1, 8'h08, 1'b1, 1'b1, 2};
        vecs[8]  = '{1'b0, 3'd0, 1'b1, 8'h40, 1'b1, 1'b1, 1};
        vecs[9]  = '{1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 0};
        vecs[10] = '{1'b1, 3'd2, 1'b1, 8'h04, 1'b1, 1'b1, 1};
        vecs[11] = '{1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 0};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_rdy_put", 32'(lnk.RDY_put), 32'd1);
        chk("rst_rdy_get", 32'(lnk.RDY_get), 32'd0);
        chk("rst_onehot",  32'(lnk.get_onehot), 32'h00);
        chk("rst_occ",     32'(occupancy), 32'd0);
        chk("rst_drop",    32'(drop_cnt), 32'd0);
        RST_N = 1'b1;

        // Single transfer, fill/drain order, get-on-empty with same-cycle put
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].pe, vecs[i].code, vecs[i].ge, 1'b0);
            chk($sformatf("vec%0d_onehot", i),  32'(lnk.get_onehot), 32'(vecs[i].exp_onehot));
            chk($sformatf("vec%0d_rdy_get", i), 32'(lnk.RDY_get),    32'(vecs[i].exp_rdy_get));
            chk($sformatf("vec%0d_rdy_put", i), 32'(lnk.RDY_put),    32'(vecs[i].exp_rdy_put));
            chk($sformatf("vec%0d_occ", i),     32'(occupancy),      32'(vecs[i].exp_occ));
        end

        // Overflow drops, one refused put alongside a get
        cycle(1'b1, 3'd7, 1'b0, 1'b0);
        cycle(1'b1, 3'd0, 1'b0, 1'b0);
        cycle(1'b1, 3'd3, 1'b0, 1'b0);
        cycle(1'b1, 3'd6, 1'b0, 1'b0);
        cycle(1'b1, 3'd1, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 1'b0, 1'b0);
        cycle(1'b1, 3'd4, 1'b1, 1'b0);
        chk("ovf_drop3", 32'(drop_cnt), 32'd3);
        chk("ovf_occ3",  32'(occupancy), 32'd3);
        chk("ovf_head",  32'(lnk.get_onehot), 32'h01);
        repeat (3) cycle(1'b0, 3'd0, 1'b1, 1'b0);
        cycle(1'b0, 3'd0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(drop_cnt), 32'd0);

        // Steady put+get at occupancy 2 across pointer wrap
        cycle(1'b1, 3'd1, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
            chk("steady_occ", 32'(occupancy), 32'd2);
        end
        repeat (2) cycle(1'b0, 3'd0, 1'b1, 1'b0);
        chk("steady_empty", 32'(lnk.RDY_get), 32'd0);

        // Drop counter saturation, then clear beats a same-cycle drop
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 3'd5, 1'b0, 1'b0);
        chk("sat_255", 32'(drop_cnt), 32'd255);
        cycle(1'b1, 3'd5, 1'b0, 1'b1);
        chk("sat_clr", 32'(drop_cnt), 32'd0);
        cycle(1'b1, 3'd5, 1'b0, 1'b0);
        chk("sat_restart", 32'(drop_cnt), 32'd1);

        // Asynchronous reset mid-traffic at occupancy 3
        repeat (4) cycle(1'b0, 3'd0, 1'b1, 1'b0);
        cycle(1'b1, 3'd1, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 1'b0, 1'b0);
        cycle(1'b1, 3'd3, 1'b0, 1'b0);
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_rdy_put", 32'(lnk.RDY_put), 32'd1);
        chk("arst_rdy_get", 32'(lnk.RDY_get), 32'd0);
        chk("arst_onehot",  32'(lnk.get_onehot), 32'h00);
        chk("arst_occ",     32'(occupancy), 32'd0);
        chk("arst_drop",    32'(drop_cnt), 32'd0);
        sb.delete();
        m_occ  = 0;
        m_drop = 0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cycle(1'b1, 3'd4, 1'b0, 1'b0);
        chk("post_rst_onehot", 32'(lnk.get_onehot), 32'h10);
        cycle(1'b0, 3'd0, 1'b1, 1'b0);
        cycle(1'b0, 3'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/enc_link_rx.md
Name: enc_link_rx

Overview:
Receive stage directly downstream of the 8-to-3 link encoder. It accepts 3-bit encoded codes over a put handshake and buffers them in a small FIFO. Each code is decoded back to an 8-bit one-hot word and presented on a get handshake. It also counts codes dropped for lack of space, so link back-pressure is visible to the consumer.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
CNT_W, 8, width of the saturating drop counter.

Ports:
CLK  input  1  single clock; all state updates on rising edge.
RST_N  input  1  reset, asynchronous, active-low.
put_code  input  3  encoded code {a2,a1,a0} from the encoder stage.
EN_put  input  1  put strobe; accepted only when RDY_put=1.
RDY_put  output  1  1 = FIFO not full.
EN_get  input  1  get strobe; honoured only when RDY_get=1.
get_onehot  output  8  decoded head entry (1 << code); 8'h00 when empty.
RDY_get  output  1  1 = FIFO not empty.
occupancy  output  log2(DEPTH)+1  number of valid entries.
clr_drops  input  1  synchronous clear of drop_cnt.
drop_cnt  output  CNT_W  saturating count of refused puts.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - RDY_put=1, RDY_get=0, get_onehot=8'h00, occupancy=0, drop_cnt=0.
  - Read and write pointers are cleared.
  - Reset mid-traffic discards all buffered entries immediately; the first put after release lands in entry 0.
- Occupancy FSM, state derived from the occupancy register:
  - EMPTY (occ=0): RDY_get=0.
  - PARTIAL (0<occ<DEPTH): both ready.
  - FULL (occ=DEPTH): RDY_put=0.
- Accepts:
  - put_fire = EN_put & RDY_put. Writes put_code at wr_ptr; wr_ptr increments modulo DEPTH.
  - get_fire = EN_get & RDY_get. rd_ptr increments modulo DEPTH.
  - put_fire only: occupancy +1. get_fire only: occupancy -1. Both or neither: unchanged.
- Latency:
  - A code accepted at edge N is visible on get_onehot/RDY_get after edge N when the FIFO was empty.
  - No combinational put-to-get bypass.
- All RDY_* and get_onehot come from registers or pointer decode only. No combinational path from EN_* to RDY_*.
- Decode: get_onehot = 8'b1 << mem[rd_ptr] when occupancy>0, else 8'h00.
  - Code 0 maps to 8'h01; code 7 maps to 8'h80.
- Full boundary:
  - EN_put with RDY_put=0 is ignored; data is discarded.
  - This holds even when a get fires in the same cycle; no pass-through when full.
  - The refused put increments drop_cnt.
- Empty boundary:
  - EN_get with RDY_get=0 is ignored, with no pointer change.
  - A same-cycle put is still accepted.
- drop_cnt:
  - +1 per cycle with EN_put=1 and RDY_put=0.
  - Saturates at 2^CNT_W-1.
  - clr_drops=1 forces 0 next edge and wins over a same-cycle drop.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. FIFO order is preserved across wrap.

Test Plan:
1. Reset then idle: RST_N low mid-run with occupancy=3 -> all outputs at reset values immediately (asynchronous); occupancy=0, RDY_put=1, get_onehot=8'h00.
2. Single transfer: put code 5 on one cycle -> next cycle RDY_get=1, get_onehot=8'h20, occupancy=1; EN_get -> RDY_get=0, get_onehot=8'h00.
3. Fill to full and order check: put codes 7,0,3,6 with DEPTH=4 -> RDY_put=0, occupancy=4; drain gives 8'h80, 8'h01, 8'h08, 8'h40 in order.
4. Overflow drops: while full, hold EN_put 3 cycles (one with a same-cycle get) -> drop_cnt=3; the FIFO contents seen on drain exclude the refused codes; clr_drops -> 0.
5. Simultaneous put/get at occupancy 2 over 10 cycles -> occupancy stays 2, pointers wrap, output sequence matches input order delayed by 2 entries.
6. Saturation: with CNT_W=8, force 300 refused puts -> drop_cnt holds 255; clr_drops asserted together with a drop -> 0.
